// File: rtl/cdiv_8b_if.sv
// Valid/ready handshake bundle for the divide-by-constant block.
interface cdiv_8b_if #(
  parameter int C_VAL = 7
);
  localparam int unsigned R_W = $clog2(C_VAL) + 1;

  logic [7:0]     in_data_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [7:0]     out_quo_o;
  logic [R_W-1:0] out_rem_o;
  logic           out_valid_o;
  logic           out_ready_i;

  // Divider side
  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_quo_o, out_rem_o, out_valid_o
  );

  // Producer/consumer side
  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_quo_o, out_rem_o, out_valid_o
  );
endinterface

// File: rtl/cdiv_8b.sv
// Sequential 8-bit divide-by-constant: restoring shift-subtract, one quotient
// bit per clock, optional two's-complement dividend with truncation toward zero.
module cdiv_8b #(
  parameter bit C_SIG = 1'b0,
  parameter int C_VAL = 7
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  cdiv_8b_if.slave  bus
);

  localparam int unsigned R_W = $clog2(C_VAL) + 1;
  localparam int unsigned P_W = R_W + 1;
  localparam logic [P_W-1:0] DIV = P_W'(C_VAL);

  // Divisor must be a positive 8-bit constant
  if (C_VAL < 1 || C_VAL > 255) begin : g_bad_cval
    $error("cdiv_8b: C_VAL must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     dvd_q, dvd_d;
  logic           sign_q, sign_d;
  logic [R_W-1:0] prem_q, prem_d;
  logic [7:0]     quo_q, quo_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     quo_out_q, quo_out_d;
  logic [R_W-1:0] rem_out_q, rem_out_d;
  logic           valid_q, valid_d;

  logic           ready_c;
  logic           accept_c;
  logic [P_W-1:0] shift_c;
  logic           ge_c;
  logic [R_W-1:0] prem_step_c;
  logic [7:0]     quo_step_c;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      sign_q    <= 1'b0;
      prem_q    <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      sign_q    <= sign_d;
      prem_q    <= prem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state, one restoring step per CALC cycle, and handshake control
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    sign_d    = sign_q;
    prem_d    = prem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    valid_d   = valid_q;
    ready_c   = 1'b0;
    accept_c  = 1'b0;

    // Partial remainder stays below C_VAL, so the shifted value fits P_W bits
    shift_c     = {prem_q, dvd_q[cnt_q]};
    ge_c        = (shift_c >= DIV);
    prem_step_c = ge_c ? R_W'(shift_c - DIV) : R_W'(shift_c);
    quo_step_c  = quo_q;
    quo_step_c[cnt_q] = ge_c;

    case (state_q)
      IDLE: begin
        ready_c  = 1'b1;
        accept_c = bus.in_valid_i;
      end
      CALC: begin
        prem_d = prem_step_c;
        quo_d  = quo_step_c;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          quo_out_d = sign_q ? 8'(-quo_step_c) : quo_step_c;
          rem_out_d = sign_q ? R_W'(-prem_step_c) : prem_step_c;
          valid_d   = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          ready_c  = 1'b1;
          valid_d  = 1'b0;
          accept_c = bus.in_valid_i;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Latch dividend magnitude and sign; -128 maps to an unsigned 128
    if (accept_c) begin
      sign_d  = C_SIG & bus.in_data_i[7];
      dvd_d   = (C_SIG && bus.in_data_i[7]) ? 8'(-bus.in_data_i) : bus.in_data_i;
      prem_d  = '0;
      quo_d   = '0;
      cnt_d   = 3'd7;
      state_d = CALC;
    end
  end

  assign bus.in_ready_o  = ready_c;
  assign bus.out_quo_o   = quo_out_q;
  assign bus.out_rem_o   = rem_out_q;
  assign bus.out_valid_o = valid_q;

endmodule

// File: tb/tb_cdiv_8b.sv
// Bench for cdiv_8b: five parameterisations driven in lockstep and checked
// against an integer-division reference model.
module tb_cdiv_8b;

  localparam int N = 5;
  localparam int SIGS [N] = '{0, 1, 1, 0, 0};
  localparam int CVS  [N] = '{7, 7, 1, 1, 255};

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic [7:0] quo [N];
  logic [8:0] rem [N];
  logic       vld [N];
  logic       rdy [N];
  logic       hold_armed [N];

  int ntests = 0;
  int nfail = 0;

  always #5 clk_i = ~clk_i;

  cdiv_8b_if #(.C_VAL(7))   bus0 ();
  cdiv_8b_if #(.C_VAL(7))   bus1 ();
  cdiv_8b_if #(.C_VAL(1))   bus2 ();
  cdiv_8b_if #(.C_VAL(1))   bus3 ();
  cdiv_8b_if #(.C_VAL(255)) bus4 ();

  cdiv_8b #(.C_SIG(1'b0), .C_VAL(7))   u0 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus0));
  cdiv_8b #(.C_SIG(1'b1), .C_VAL(7))   u1 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus1));
  cdiv_8b #(.C_SIG(1'b1), .C_VAL(1))   u2 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus2));
  cdiv_8b #(.C_SIG(1'b0), .C_VAL(1))   u3 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus3));
  cdiv_8b #(.C_SIG(1'b0), .C_VAL(255)) u4 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus4));

  assign bus0.in_data_i = in_data;  assign bus0.in_valid_i = in_valid;  assign bus0.out_ready_i = out_ready;
  assign bus1.in_data_i = in_data;  assign bus1.in_valid_i = in_valid;  assign bus1.out_ready_i = out_ready;
  assign bus2.in_data_i = in_data;  assign bus2.in_valid_i = in_valid;  assign bus2.out_ready_i = out_ready;
  assign bus3.in_data_i = in_data;  assign bus3.in_valid_i = in_valid;  assign bus3.out_ready_i = out_ready;
  assign bus4.in_data_i = in_data;  assign bus4.in_valid_i = in_valid;  assign bus4.out_ready_i = out_ready;

  assign quo[0] = bus0.out_quo_o;  assign rem[0] = 9'(bus0.out_rem_o);
  assign quo[1] = bus1.out_quo_o;  assign rem[1] = 9'(bus1.out_rem_o);
  assign quo[2] = bus2.out_quo_o;  assign rem[2] = 9'(bus2.out_rem_o);
  assign quo[3] = bus3.out_quo_o;  assign rem[3] = 9'(bus3.out_rem_o);
  assign quo[4] = bus4.out_quo_o;  assign rem[4] = 9'(bus4.out_rem_o);
  assign vld[0] = bus0.out_valid_o; assign rdy[0] = bus0.in_ready_o;
  assign vld[1] = bus1.out_valid_o; assign rdy[1] = bus1.in_ready_o;
  assign vld[2] = bus2.out_valid_o; assign rdy[2] = bus2.in_ready_o;
  assign vld[3] = bus3.out_valid_o; assign rdy[3] = bus3.in_ready_o;
  assign vld[4] = bus4.out_valid_o; assign rdy[4] = bus4.in_ready_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV truncates toward zero and the
  // remainder follows the dividend's sign. Remainder is cut to R_W bits.
  function automatic void ref_div(input int sig, input int cv, input logic [7:0] d,
                                  output logic [7:0] q, output logic [8:0] r);
    int dv, qi, ri, rw;
    dv = sig ? int'($signed(d)) : int'(d);
    qi = dv / cv;
    ri = dv % cv;
    rw = $clog2(cv) + 1;
    q  = 8'(qi);
    r  = 9'(ri) & 9'((1 << rw) - 1);
  endfunction

  task automatic chk_results(input logic [7:0] d, input string what);
    logic [7:0] eq;
    logic [8:0] er;
    for (int i = 0; i < N; i++) begin
      ref_div(SIGS[i], CVS[i], d, eq, er);
      chk($sformatf("%s_vld%0d_d%0d", what, i, d), 32'(vld[i]), 32'd1);
      chk($sformatf("%s_quo%0d_d%0d", what, i, d), 32'(quo[i]), 32'(eq));
      chk($sformatf("%s_rem%0d_d%0d", what, i, d), 32'(rem[i]), 32'(er));
    end
  endtask

  task automatic chk_all_rdy(input string tag, input logic exp);
    for (int i = 0; i < N; i++) chk($sformatf("%s%0d", tag, i), 32'(rdy[i]), 32'(exp));
  endtask

  task automatic chk_all_vld(input string tag, input logic exp);
    for (int i = 0; i < N; i++) chk($sformatf("%s%0d", tag, i), 32'(vld[i]), 32'(exp));
  endtask

  // Wait for the result, bounded; returns clocks taken after the accept edge
  task automatic wait_result(output int n);
    n = 0;
    while (vld[0] !== 1'b1 && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  // One transaction from IDLE: accept, latency, result, optional backpressure
  task automatic run_op(input logic [7:0] d, input int hold);
    int n;
    chk_all_rdy("idle_rdy", 1'b1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk_i); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    chk_all_rdy("calc_rdy", 1'b0);
    wait_result(n);
    chk("latency", 32'(n), 32'd8);
    chk_results(d, "res");
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(posedge clk_i); #1;
      chk_results(d, "hold");
      chk_all_rdy("hold_rdy", 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk_i); #1;
    out_ready = 1'b0;
    chk_all_vld("hs_vld", 1'b0);
    chk_all_rdy("hs_rdy", 1'b1);
  endtask

  // out_valid_o may only fall after an edge where it was accepted
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N; i++) hold_armed[i] <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hold_armed[i]) chk($sformatf("vhold%0d", i), 32'(vld[i]), 32'd1);
        hold_armed[i] <= vld[i] & ~out_ready;
      end
    end
  end

  initial begin
    int n;
    logic [7:0] last_quo;

    // Reset values
    #2;
    chk_all_vld("rst_vld", 1'b0);
    chk_all_rdy("rst_rdy", 1'b1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_quo%0d", i), 32'(quo[i]), 32'd0);
      chk($sformatf("rst_rem%0d", i), 32'(rem[i]), 32'd0);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Directed operands, including sign and divisor corner cases
    run_op(8'd200, 0);
    run_op(8'h9C, 0);
    run_op(8'h64, 0);
    run_op(8'h80, 0);
    run_op(8'd255, 0);
    run_op(8'd254, 0);
    run_op(8'h00, 0);
    run_op(8'h7F, 0);
    run_op(8'hFF, 0);

    // Backpressure with ignored input pulses
    run_op(8'd123, 20);

    // Back-to-back: second dividend accepted on the first handshake edge
    in_data   = 8'd50;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk_i); #1;
    in_data = 8'd51;
    wait_result(n);
    chk("b2b_lat1", 32'(n), 32'd8);
    chk_results(8'd50, "b2b1");
    chk_all_rdy("b2b_done_rdy", 1'b1);
    @(posedge clk_i); #1;
    in_valid = 1'b0;
    chk_all_vld("b2b_drop", 1'b0);
    chk_all_rdy("b2b_calc_rdy", 1'b0);
    wait_result(n);
    chk("b2b_spacing", 32'(n + 1), 32'd9);
    chk_results(8'd51, "b2b2");
    @(posedge clk_i); #1;
    out_ready = 1'b0;
    chk_all_vld("b2b_end_vld", 1'b0);
    chk_all_rdy("b2b_end_rdy", 1'b1);

    // Reset in the middle of CALC
    last_quo = quo[0];
    chk("pre_rst_quo_nonzero", 32'(last_quo != 8'd0), 32'd1);
    in_data  = 8'd100;
    in_valid = 1'b1;
    @(posedge clk_i); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk_i);
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    #1;
    chk_all_vld("mid_rst_vld", 1'b0);
    chk_all_rdy("mid_rst_rdy", 1'b1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("mid_rst_quo%0d", i), 32'(quo[i]), 32'd0);
      chk($sformatf("mid_rst_rem%0d", i), 32'(rem[i]), 32'd0);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk_all_vld("post_rst_vld", 1'b0);
    run_op(8'd100, 0);

    // Random operands with random backpressure
    for (int k = 0; k < 40; k++) begin
      run_op(8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/cdiv_8b.md
Name: cdiv_8b

Overview:
- Sequential divide-by-constant for 8-bit operands. It is the inverse companion of the team's constant multiplier.
- Produces quotient and remainder of in_data_i / C_VAL using an iterative restoring shift-subtract, one quotient bit per clock.
- Sits in the math library next to the cmul blocks. Used where fixed-ratio scaling or decimation needs both quotient and remainder.
- Handshaked on both sides so it can sit in valid/ready datapaths.

Parameters:
- C_SIG, 0: 0 = unsigned dividend; 1 = two's-complement dividend, quotient truncated toward zero, remainder takes the dividend's sign.
- C_VAL, 7: positive constant divisor, 1..255. Values below 1 are an elaboration-time $error.
- R_W, $clog2(C_VAL)+1: remainder width, derived (not to be overridden). Magnitude plus sign room.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- in_data_i  in  8  dividend
- in_valid_i  in  1  dividend valid
- in_ready_o  out  1  block can accept dividend
- out_quo_o  out  8  quotient
- out_rem_o  out  R_W  remainder; zero-extended if C_SIG=0, sign-extended if C_SIG=1
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: state=IDLE, out_valid_o=0, out_quo_o=0, out_rem_o=0, bit counter=0, internal regs=0. in_ready_o is 1 while in IDLE.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1.
  - On an edge with in_valid_i=1: latch magnitude of dividend into working reg and latch sign (sign=in_data_i[7] & C_SIG); clear partial remainder; counter=7; go to CALC.
- CALC:
  - in_ready_o=0.
  - Each edge: shift partial remainder left, bringing in dividend bit[counter]. If partial ≥ C_VAL, subtract C_VAL and set quotient bit[counter]=1, else 0. Decrement counter.
  - After the counter=0 step: apply sign correction (negate quotient and remainder if sign=1), register outputs, out_valid_o=1, go to DONE.
  - Partial-remainder datapath is R_W bits wide; it never exceeds 2*C_VAL-1 before the compare.
- DONE:
  - out_valid_o=1. Outputs stable until the handshake completes.
  - On an edge with out_ready_i=1: out_valid_o=0.
    - If in_valid_i=1 on the same edge, accept the new dividend and go to CALC.
    - Otherwise go to IDLE.
- Ready path: in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). This is a combinational path from out_ready_i; the only one permitted.
- Latency:
  - Accept edge E0, CALC edges E1..E8; out_valid_o is high after E8.
  - Eight clocks from accept to result.
  - Max throughput: one result per 9 clocks (back-to-back via DONE→CALC).
- Arithmetic corner cases:
  - Signed -128 magnitude is 128, representable as unsigned 8-bit; the negated quotient wraps correctly (-128/1 → 0x80).
  - C_VAL=1: remainder always 0, quotient = dividend.
  - Quotient is the low 8 bits after negation.
- Input ignored: in_valid_i while in CALC or in DONE without out_ready_i. The source must hold its data.
- Reset mid-operation: asynchronous reset in CALC or DONE aborts the division and returns to the reset values at once. No partial result is emitted.
- Valid hold: out_valid_o must not drop without out_ready_i. Checked by assertion.

Test Plan:
- C_SIG=0, C_VAL=7, in 200, out_ready_i=1 → out_valid_o high exactly 8 clocks after accept; quo=28, rem=4 (R_W=4, 4'h4).
- C_SIG=1, C_VAL=7, in 0x9C (-100) → quo=0xF2 (-14), rem=4'hE (-2). Then in 0x64 (+100) → quo=0x0E, rem=4'h2.
- C_SIG=1, C_VAL=1: in 0x80 → quo=0x80, rem=0. C_SIG=0, C_VAL=1: in 255 → quo=255, rem=0. C_SIG=0, C_VAL=255: in 254 → quo=0, rem=254.
- Backpressure: out_ready_i=0 for 20 clocks after result → out_valid_o, quo and rem held constant; in_ready_o=0 throughout; in_valid_i pulses ignored.
- Back-to-back: in_valid_i held high with inputs 50, 51 (C_VAL=7, unsigned), out_ready_i=1 → second accept occurs on the first result's handshake edge; results (7,1) then (7,2) spaced 9 clocks apart.
- Reset: assert rst_n_i low at CALC edge E4 → outputs go to 0 asynchronously, state IDLE; after release, in_ready_o=1 and a fresh 100/7 gives quo=14, rem=2.
